// File: rtl/sample_source_if.sv
// sample_source_if
// Groups the bus control and the sample stream around sample_source.
// The bidirectional data byte stays a plain inout port on the module so that
// the tristate resolves at the top level.
//   address   : internal bus address
//   rd, wr    : bus read / write strobes
//   adc_valid : one-cycle strobe, new ADC sample on adc_data
//   adc_data  : ADC sample, WIDTH bits
//   out_valid : one-cycle strobe towards the 12-to-8 packer
//   out_bits  : sample towards the packer, held between strobes
// master = bus master / ADC / packer side, slave = sample_source.
interface sample_source_if #(
  parameter int WIDTH = 12
);
  logic [7:0]       address;
  logic             rd;
  logic             wr;
  logic             adc_valid;
  logic [WIDTH-1:0] adc_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_bits;

  modport master (
    output address, rd, wr, adc_valid, adc_data,
    input  out_valid, out_bits
  );

  modport slave (
    input  address, rd, wr, adc_valid, adc_data,
    output out_valid, out_bits
  );
endinterface

// File: rtl/sample_source.sv
// sample_source
// Selects the sample stream fed to the 12-to-8 packer: live ADC data, a
// sawtooth, an LFSR pattern or a programmable constant, with decimation.
// Control changes only take effect on even sample boundaries so the packer
// never loses byte alignment.
//   clk    : system clock
//   nreset : synchronous reset, active low
//   data   : 8-bit bidirectional bus data, driven only during in-range reads
//   bus    : sample_source_if slave (address/rd/wr, ADC input, packer output)
// Register map at BASEADDR: +0 CTRL, +1 DECIM, +2 CONST_LO, +3 CONST_HI,
// +4 STATUS (read-only).
module sample_source #(
  parameter int               WIDTH     = 12,
  parameter logic [7:0]       BASEADDR  = 8'h20,
  parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(12'hE08)
) (
  input  logic  clk,
  input  logic  nreset,
  inout  wire [7:0] data,
  sample_source_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ADC   = 2'd0,
    MODE_SAW   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_t;

  logic [7:0]       offset;
  logic             in_range;
  logic [2:0]       ctrl;
  logic [7:0]       decim;
  logic [WIDTH-1:0] const_val;
  logic             pending;
  logic             act_en;
  mode_t            act_mode;
  logic             phase;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] saw;
  logic [WIDTH-1:0] lfsr;
  logic             tick;
  logic             emit;
  logic             apply;
  logic             wr_ctrl;
  logic [WIDTH-1:0] sample;
  logic [7:0]       rd_value;

  // Addresses below BASEADDR wrap to large offsets and fall out of range.
  assign offset   = bus.address - BASEADDR;
  assign in_range = (offset <= 8'd4);
  assign wr_ctrl  = bus.wr && in_range && (offset == 8'd0);

  assign tick  = bus.adc_valid && act_en;
  assign emit  = tick && (cnt == decim);
  // Phase is always 0 while disabled, so a disabled block applies at once.
  assign apply = pending && !phase;

  // Register read mux; CTRL returns the last written value, not the active one.
  always_comb begin
    rd_value = 8'h00;
    case (offset[2:0])
      3'd0:    rd_value = {5'b00000, ctrl};
      3'd1:    rd_value = decim;
      3'd2:    rd_value = const_val[7:0];
      3'd3:    rd_value = 8'(const_val[WIDTH-1:8]);
      3'd4:    rd_value = {3'b000, phase, act_mode, act_en, pending};
      default: rd_value = 8'h00;
    endcase
  end

  assign data = (bus.rd && in_range) ? rd_value : 8'bz;

  always_comb begin
    sample = bus.adc_data;
    case (act_mode)
      MODE_ADC:   sample = bus.adc_data;
      MODE_SAW:   sample = saw;
      MODE_LFSR:  sample = lfsr;
      MODE_CONST: sample = const_val;
      default:    sample = bus.adc_data;
    endcase
  end

  // Bus-writable registers; STATUS and unmapped addresses ignore writes.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      ctrl      <= 3'd0;
      decim     <= 8'd0;
      const_val <= '0;
    end else if (bus.wr && in_range) begin
      case (offset[2:0])
        3'd0:    ctrl <= data[2:0];
        3'd1:    decim <= data;
        3'd2:    const_val[7:0] <= data;
        3'd3:    const_val[WIDTH-1:8] <= data[WIDTH-9:0];
        default: ;
      endcase
    end
  end

  // A new write re-arms pending even in the cycle the previous one applies.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      pending <= 1'b0;
    end else if (wr_ctrl) begin
      pending <= 1'b1;
    end else if (apply) begin
      pending <= 1'b0;
    end
  end

  // Active control, decimation, phase and pattern generators. A tick in the
  // apply cycle is emitted under the old source, but the restart of the
  // counters and generators for the new source takes priority.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      act_en   <= 1'b0;
      act_mode <= MODE_ADC;
      phase    <= 1'b0;
      cnt      <= 8'd0;
      saw      <= '0;
      lfsr     <= WIDTH'(1);
    end else if (apply) begin
      act_en   <= ctrl[0];
      act_mode <= mode_t'(ctrl[2:1]);
      phase    <= ctrl[0] & emit;
      cnt      <= 8'd0;
      saw      <= '0;
      lfsr     <= WIDTH'(1);
    end else begin
      if (tick) begin
        cnt <= emit ? 8'd0 : cnt + 8'd1;
      end
      if (emit) begin
        phase <= ~phase;
        if (act_mode == MODE_SAW) begin
          saw <= saw + WIDTH'(1);
        end
        if (act_mode == MODE_LFSR) begin
          lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
        end
      end
    end
  end

  // Registered output; out_bits holds between strobes.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      bus.out_valid <= 1'b0;
      bus.out_bits  <= '0;
    end else begin
      bus.out_valid <= emit;
      if (emit) begin
        bus.out_bits <= sample;
      end
    end
  end

endmodule
